// File: rtl/write_back_if.sv
// Write-back request / commit / register-read bundle between the pipeline and write_back_regfile.
interface write_back_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              wb_valid;
  logic              wb_ready;
  logic              reg_write;
  logic              mem_to_reg;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_data;
  logic              commit_en;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              commit_valid;
  logic [ADDR_W-1:0] commit_reg;
  logic [DATA_W-1:0] commit_data;
  logic [ADDR_W-1:0] wb_count;

  modport master (
    output wb_valid, reg_write, mem_to_reg, write_reg, alu_result, mem_data,
           commit_en, rs, rt,
    input  wb_ready, read_data1, read_data2, commit_valid, commit_reg,
           commit_data, wb_count
  );

  modport slave (
    input  wb_valid, reg_write, mem_to_reg, write_reg, alu_result, mem_data,
           commit_en, rs, rt,
    output wb_ready, read_data1, read_data2, commit_valid, commit_reg,
           commit_data, wb_count
  );
endinterface

// File: rtl/write_back_regfile.sv
// Write-back queue plus 32-entry register bank with two combinational read ports.
// Optional macro WB_BYPASS_EN: read ports forward the data being committed this cycle.
module write_back_regfile #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  write_back_if.slave bus
);
  localparam int unsigned NREG  = 1 << ADDR_W;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic              reg_write;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  wb_entry_t         fifo_q [FIFO_DEPTH];
  wb_entry_t         fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              commit_valid_q, commit_valid_d;
  logic [ADDR_W-1:0] commit_reg_q, commit_reg_d;
  logic [DATA_W-1:0] commit_data_q, commit_data_d;

  logic              push_c;
  logic              pop_c;
  logic              head_writes_c;
  wb_entry_t         head_c;

  // Handshake decisions use the registered count only, so a full queue never accepts on a pop cycle.
  always_comb begin
    push_c        = bus.wb_valid && (count_q < CNT_W'(FIFO_DEPTH));
    pop_c         = (count_q != '0) && bus.commit_en;
    head_c        = fifo_q[rd_ptr_q];
    head_writes_c = pop_c && head_c.reg_write && (head_c.dest != '0);
  end

  // Queue storage, pointers and occupancy.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      fifo_d[wr_ptr_q].reg_write = bus.reg_write;
      fifo_d[wr_ptr_q].dest      = bus.write_reg;
      fifo_d[wr_ptr_q].data      = bus.mem_to_reg ? bus.mem_data : bus.alu_result;
      wr_ptr_d                   = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Commit: register bank update and the commit report, which holds its last value between pulses.
  always_comb begin
    regs_d         = regs_q;
    commit_valid_d = pop_c;
    commit_reg_d   = commit_reg_q;
    commit_data_d  = commit_data_q;
    if (pop_c) begin
      commit_reg_d  = head_c.dest;
      commit_data_d = head_c.data;
    end
    if (head_writes_c) begin
      regs_d[head_c.dest] = head_c.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= DATA_W'(i);
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_reg_q   <= '0;
      commit_data_q  <= '0;
    end else begin
      fifo_q         <= fifo_d;
      regs_q         <= regs_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_reg_q   <= commit_reg_d;
      commit_data_q  <= commit_data_d;
    end
  end

  // Read ports: R0 hard-wired to zero; optional forwarding of the committing head entry.
  always_comb begin
    bus.read_data1 = (bus.rs == '0) ? '0 : regs_q[bus.rs];
    bus.read_data2 = (bus.rt == '0) ? '0 : regs_q[bus.rt];
`ifdef WB_BYPASS_EN
    if (head_writes_c && (head_c.dest == bus.rs)) bus.read_data1 = head_c.data;
    if (head_writes_c && (head_c.dest == bus.rt)) bus.read_data2 = head_c.data;
`endif
  end

  assign bus.wb_ready     = (count_q < CNT_W'(FIFO_DEPTH));
  assign bus.wb_count     = ADDR_W'(count_q);
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_reg   = commit_reg_q;
  assign bus.commit_data  = commit_data_q;

endmodule

// File: tb/tb_write_back_regfile.sv
// Directed + random bench for write_back_regfile with a commit scoreboard and register model.
module tb_write_back_regfile;
  localparam int DEPTH = 2;

  typedef struct {
    logic        rw;
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  write_back_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  write_back_regfile #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          tests = 0;
  int          fails = 0;
  ent_t        sb[$];
  logic [31:0] model[32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < 32; i++) model[i] = 32'(i);
  endtask

  // One clock: predict accept/commit from the model, advance, then compare.
  task automatic step();
    logic exp_cv;
    logic exp_rdy;
    ent_t head;
    ent_t ne;
    exp_cv  = rst_n && bus.commit_en && (sb.size() != 0);
    exp_rdy = (sb.size() < DEPTH);
    head    = '{rw: 1'b0, dest: 5'd0, data: 32'd0};
    if (exp_cv) head = sb[0];
    chk("wb_ready", 32'(bus.wb_ready), 32'(exp_rdy));
    if (bus.wb_valid && exp_rdy) begin
      ne.rw   = bus.reg_write;
      ne.dest = bus.write_reg;
      ne.data = bus.mem_to_reg ? bus.mem_data : bus.alu_result;
      sb.push_back(ne);
    end
    @(posedge clk);
    #1;
    chk("commit_valid", 32'(bus.commit_valid), 32'(exp_cv));
    if (exp_cv) begin
      void'(sb.pop_front());
      chk("commit_reg", 32'(bus.commit_reg), 32'(head.dest));
      chk("commit_data", bus.commit_data, head.data);
      if (head.rw && head.dest != 5'd0) model[head.dest] = head.data;
    end
    chk("wb_count", 32'(bus.wb_count), 32'(sb.size()));
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic [4:0] dest,
                       input logic [31:0] alu, input logic [31:0] mem);
    bus.wb_valid   = 1'b1;
    bus.reg_write  = rw;
    bus.mem_to_reg = m2r;
    bus.write_reg  = dest;
    bus.alu_result = alu;
    bus.mem_data   = mem;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.wb_valid   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.write_reg  = 5'd0;
    bus.alu_result = 32'd0;
    bus.mem_data   = 32'd0;
    bus.commit_en  = 1'b0;
    bus.rs         = 5'd5;
    bus.rt         = 5'd0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state
    chk("rst_rd1", bus.read_data1, 32'd5);
    chk("rst_rd2", bus.read_data2, 32'd0);
    chk("rst_ready", 32'(bus.wb_ready), 32'd1);
    chk("rst_count", 32'(bus.wb_count), 32'd0);
    chk("rst_cv", 32'(bus.commit_valid), 32'd0);
    chk("rst_creg", 32'(bus.commit_reg), 32'd0);
    chk("rst_cdata", bus.commit_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU result to r8, one-cycle commit latency
    bus.commit_en = 1'b1;
    drive(1'b1, 1'b0, 5'd8, 32'hDEADBEEF, 32'h0BAD0BAD);
    step();
    bus.wb_valid = 1'b0;
    step();
    chk("t2_cv", 32'(bus.commit_valid), 32'd1);
    chk("t2_creg", 32'(bus.commit_reg), 32'd8);
    chk("t2_cdata", bus.commit_data, 32'hDEADBEEF);
    bus.rs = 5'd8;
    #1;
    chk("t2_rd1", bus.read_data1, 32'hDEADBEEF);
    step();

    // Memory data to r0: pulses but never writes
    drive(1'b1, 1'b1, 5'd0, 32'h00000111, 32'h12345678);
    step();
    bus.wb_valid = 1'b0;
    step();
    chk("t3_creg", 32'(bus.commit_reg), 32'd0);
    chk("t3_cdata", bus.commit_data, 32'h12345678);
    bus.rs = 5'd0;
    #1;
    chk("t3_r0", bus.read_data1, 32'd0);

    // Fill with commit stalled, third push held until space frees
    bus.commit_en = 1'b0;
    drive(1'b1, 1'b0, 5'd3, 32'hA, 32'h0);
    step();
    drive(1'b1, 1'b0, 5'd4, 32'hB, 32'h0);
    step();
    chk("t4_ready_full", 32'(bus.wb_ready), 32'd0);
    chk("t4_count_full", 32'(bus.wb_count), 32'd2);
    drive(1'b1, 1'b0, 5'd5, 32'hC, 32'h0);
    step();
    chk("t4_count_held", 32'(bus.wb_count), 32'd2);
    bus.commit_en = 1'b1;
    step();
    bus.rs = 5'd3;
    #1;
    chk("t4_r3", bus.read_data1, 32'hA);
    step();
    bus.wb_valid = 1'b0;
    bus.rs = 5'd4;
    #1;
    chk("t4_r4", bus.read_data1, 32'hB);
    step();
    bus.rs = 5'd5;
    #1;
    chk("t4_r5", bus.read_data1, 32'hC);

    // Read of a register in its commit cycle
    bus.commit_en = 1'b0;
    drive(1'b1, 1'b0, 5'd9, 32'h55, 32'h0);
    step();
    bus.wb_valid = 1'b0;
    bus.rs = 5'd9;
    #1;
    chk("t5_stalled", bus.read_data1, 32'd9);
    bus.commit_en = 1'b1;
    #1;
`ifdef WB_BYPASS_EN
    chk("t5_commit_cycle", bus.read_data1, 32'h55);
`else
    chk("t5_commit_cycle", bus.read_data1, 32'd9);
`endif
    step();
    chk("t5_after", bus.read_data1, 32'h55);

    // Reset with entries queued discards them
    bus.commit_en = 1'b0;
    drive(1'b1, 1'b0, 5'd10, 32'h77, 32'h0);
    step();
    drive(1'b1, 1'b0, 5'd11, 32'h88, 32'h0);
    step();
    bus.wb_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    bus.rs = 5'd10;
    bus.rt = 5'd11;
    #1;
    chk("t6_count", 32'(bus.wb_count), 32'd0);
    chk("t6_cv", 32'(bus.commit_valid), 32'd0);
    chk("t6_r8", 32'(dut.regs_q[8]), 32'd8);
    chk("t6_rd1", bus.read_data1, 32'd10);
    chk("t6_rd2", bus.read_data2, 32'd11);
    #1;
    rst_n = 1'b1;
    bus.commit_en = 1'b1;
    step();
    step();
    chk("t6_rd1_after", bus.read_data1, 32'd10);

    // Random traffic exercising pointer wrap and stalls
    for (int n = 0; n < 80; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom, $urandom);
      bus.wb_valid  = 1'($urandom_range(0, 1));
      bus.commit_en = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.wb_valid  = 1'b0;
    bus.commit_en = 1'b1;
    for (int n = 0; n < 4; n++) step();
    chk("drain_empty", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.rs = 5'(i);
      bus.rt = 5'(31 - i);
      #1;
      chk("final_rd1", bus.read_data1, (i == 0) ? 32'd0 : model[i]);
      chk("final_rd2", bus.read_data2, (i == 31) ? 32'd0 : model[31 - i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
